instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//  Instruction fetch stage that sits between the core control unit and IRAM.
//  Drives the IRAM address, collects opcode words (plus the operand word for operand-bearing opcodes),
//  and hands complete instructions to the control unit over a valid/ready handshake.
//  Follows JUMP itself; waits for the control unit to resolve JPNZ/JPPZ; stops on ENDOP.
// PARAMETERS
//  ADDR_W      16      IRAM address / PC width
//  DATA_W      16      instruction word width
//  RESET_PC    16'd0   PC loaded at reset
// PORTS
//  clk            in   1       system clock, all logic on posedge
//  rst_n          in   1       synchronous active-low reset
//  start          in   1       begin fetching at current PC (sampled only in IDLE)
//  iram_addr      out  ADDR_W  IRAM address (registered)
//  iram_data      in   DATA_W  IRAM data_out (valid 1 cycle after iram_addr)
//  instr_valid    out  1       instruction on instr_* outputs is complete
//  instr_ready    in   1       control unit accepts instruction this cycle
//  instr_opcode   out  DATA_W  opcode word
//  instr_operand  out  DATA_W  operand word (0 when instr_has_opr=0)
//  instr_has_opr  out  1       opcode carried an operand word
//  instr_pc       out  ADDR_W  address of the opcode word
//  br_done        in   1       JPNZ/JPPZ resolved by control unit (1-cycle pulse)
//  br_taken       in   1       with br_done: branch taken, target = instr_operand
//  halted         out  1       ENDOP accepted; fetch stopped
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state IDLE, pc=RESET_PC, all outputs 0 (iram_addr=RESET_PC).
//  Operand-bearing opcodes: LDAC=5 STAC=7 LDA=9 LDB=14 LDC=19 STC=24 JUMP=46 JPNZ=48 JPPZ=62.
//   ENDOP=51. Any other value is a 1-word instruction. No decode beyond this.
//  FSM states:
//   IDLE   : start=1 -> OP_A.
//   OP_A   : iram_addr=pc -> OP_D.
//   OP_D   : latch opcode=iram_data, instr_pc=pc, pc=pc+1.
//            Operand-bearing -> OPR_A; otherwise operand=0 -> PRES.
//   OPR_A  : iram_addr=pc -> OPR_D.
//   OPR_D  : latch operand=iram_data, pc=pc+1 -> PRES.
//   PRES   : instr_valid=1. instr_* held stable while instr_ready=0.
//            On instr_ready=1, instr_valid drops next cycle:
//              ENDOP -> HALT;
//              JUMP -> pc=operand, OP_A;
//              JPNZ/JPPZ -> BRW;
//              else -> OP_A.
//   BRW    : wait for br_done. br_taken=1 -> pc=operand; else pc unchanged. -> OP_A.
//   HALT   : halted=1; exit only via reset. start ignored.
//  Latency: start edge -> instr_valid after 3 cycles for 1-word instructions, 5 for 2-word.
//   Each following instruction takes the same 3 or 5 cycles after the accept edge.
//  PC arithmetic is modulo 2^ADDR_W: 0xFFFF+1 -> 0x0000, no error flag.
//  br_done outside BRW and start outside IDLE are ignored.
//  Reset mid-operation: all in-flight words discarded; instr_valid low in the cycle after reset.
//  No speculative fetch: IRAM address changes only in OP_A/OPR_A.
// TESTING
//  1. Reset, IRAM[0]=CLAC(35), [1]=ENDOP, start pulse, ready=1
//     -> valid with opcode 35, pc 0, has_opr 0 at cycle 3; then ENDOP pc 1; halted=1.
//  2. IRAM[0]=LDAC, [1]=7, ready=1
//     -> opcode 5, operand 7, has_opr 1, valid at cycle 5; next fetch at pc 2.
//  3. ready held low 4 cycles while valid
//     -> outputs unchanged, iram_addr frozen, single accept on ready.
//  4. IRAM[10]=JUMP, [11]=3
//     -> after accept next instr_pc=3, no br_done needed.
//     JPNZ [20],[21]=8: br_done+br_taken=1 -> next pc 8; br_taken=0 -> next pc 22.
//  5. RESET_PC=16'hFFFF, IRAM[FFFF]=INAC(34)
//     -> instr_pc FFFF, next fetch iram_addr 0000.
//  6. rst_n low during OPR_D and during BRW
//     -> next cycle state IDLE, valid=0, halted=0, iram_addr=RESET_PC; needs start again.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch stage: walks IRAM from the PC, assembles 1- or 2-word
// instructions and presents them to the control unit over valid/ready.
module instr_fetch #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] iram_addr,
  input  logic [DATA_W-1:0] iram_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_opcode,
  output logic [DATA_W-1:0] instr_operand,
  output logic              instr_has_opr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              br_done,
  input  logic              br_taken,
  output logic              halted
);

  localparam logic [DATA_W-1:0] OP_LDAC  = DATA_W'(5);
  localparam logic [DATA_W-1:0] OP_STAC  = DATA_W'(7);
  localparam logic [DATA_W-1:0] OP_LDA   = DATA_W'(9);
  localparam logic [DATA_W-1:0] OP_LDB   = DATA_W'(14);
  localparam logic [DATA_W-1:0] OP_LDC   = DATA_W'(19);
  localparam logic [DATA_W-1:0] OP_STC   = DATA_W'(24);
  localparam logic [DATA_W-1:0] OP_JUMP  = DATA_W'(46);
  localparam logic [DATA_W-1:0] OP_JPNZ  = DATA_W'(48);
  localparam logic [DATA_W-1:0] OP_ENDOP = DATA_W'(51);
  localparam logic [DATA_W-1:0] OP_JPPZ  = DATA_W'(62);

  typedef enum logic [2:0] {
    S_IDLE, S_OP_A, S_OP_D, S_OPR_A, S_OPR_D, S_PRES, S_BRW, S_HALT
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] iram_addr_q, iram_addr_d;
  logic [DATA_W-1:0] opcode_q, opcode_d;
  logic [DATA_W-1:0] operand_q, operand_d;
  logic              has_opr_q, has_opr_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;

  function automatic logic has_operand(input logic [DATA_W-1:0] op);
    case (op)
      OP_LDAC, OP_STAC, OP_LDA, OP_LDB, OP_LDC, OP_STC,
      OP_JUMP, OP_JPNZ, OP_JPPZ: has_operand = 1'b1;
      default:                   has_operand = 1'b0;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    iram_addr_d = iram_addr_q;
    opcode_d    = opcode_q;
    operand_d   = operand_q;
    has_opr_d   = has_opr_q;
    instr_pc_d  = instr_pc_q;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_OP_A;
      end
      S_OP_A:  state_d = S_OP_D;
      S_OP_D: begin
        opcode_d   = iram_data;
        instr_pc_d = pc_q;
        pc_d       = pc_q + ADDR_W'(1);
        if (has_operand(iram_data)) begin
          has_opr_d = 1'b1;
          state_d   = S_OPR_A;
        end else begin
          has_opr_d = 1'b0;
          operand_d = '0;
          state_d   = S_PRES;
        end
      end
      S_OPR_A: state_d = S_OPR_D;
      S_OPR_D: begin
        operand_d = iram_data;
        pc_d      = pc_q + ADDR_W'(1);
        state_d   = S_PRES;
      end
      S_PRES: begin
        if (instr_ready) begin
          case (opcode_q)
            OP_ENDOP: state_d = S_HALT;
            OP_JUMP: begin
              pc_d    = ADDR_W'(operand_q);
              state_d = S_OP_A;
            end
            OP_JPNZ, OP_JPPZ: state_d = S_BRW;
            default:          state_d = S_OP_A;
          endcase
        end
      end
      S_BRW: begin
        if (br_done) begin
          if (br_taken) pc_d = ADDR_W'(operand_q);
          state_d = S_OP_A;
        end
      end
      S_HALT: state_d = S_HALT;
    endcase

    // The address register is loaded on entry to an address phase so the
    // registered IRAM read has the word ready during the following data phase.
    if (state_d == S_OP_A || state_d == S_OPR_A) iram_addr_d = pc_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      iram_addr_q <= RESET_PC;
      opcode_q    <= '0;
      operand_q   <= '0;
      has_opr_q   <= 1'b0;
      instr_pc_q  <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      iram_addr_q <= iram_addr_d;
      opcode_q    <= opcode_d;
      operand_q   <= operand_d;
      has_opr_q   <= has_opr_d;
      instr_pc_q  <= instr_pc_d;
    end
  end

  assign iram_addr     = iram_addr_q;
  assign instr_valid   = (state_q == S_PRES);
  assign instr_opcode  = opcode_q;
  assign instr_operand = operand_q;
  assign instr_has_opr = has_opr_q;
  assign instr_pc      = instr_pc_q;
  assign halted        = (state_q == S_HALT);

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: IRAM model, scoreboard of expected instructions
// popped on every accepted handshake, plus directed latency/boundary checks.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n, start, start_b, instr_ready, br_done, br_taken;
  logic [15:0] iram_addr, iram_data, iram_addr_b, iram_data_b;
  logic        instr_valid, instr_has_opr, halted;
  logic [15:0] instr_opcode, instr_operand, instr_pc;
  logic        valid_b, has_opr_b, halted_b;
  logic [15:0] opcode_b, operand_b, pc_b;

  logic [15:0] mem [0:65535];

  typedef struct packed {
    logic [15:0] op;
    logic [15:0] opr;
    logic        has;
    logic [15:0] pc;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int failures = 0;
  int n;

  always #5 clk = ~clk;

  always @(posedge clk) iram_data   <= mem[iram_addr];
  always @(posedge clk) iram_data_b <= mem[iram_addr_b];

  instr_fetch #(.ADDR_W(16), .DATA_W(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .iram_addr(iram_addr), .iram_data(iram_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_opcode(instr_opcode), .instr_operand(instr_operand),
    .instr_has_opr(instr_has_opr), .instr_pc(instr_pc),
    .br_done(br_done), .br_taken(br_taken), .halted(halted)
  );

  instr_fetch #(.ADDR_W(16), .DATA_W(16), .RESET_PC(16'hFFFF)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b),
    .iram_addr(iram_addr_b), .iram_data(iram_data_b),
    .instr_valid(valid_b), .instr_ready(instr_ready),
    .instr_opcode(opcode_b), .instr_operand(operand_b),
    .instr_has_opr(has_opr_b), .instr_pc(pc_b),
    .br_done(br_done), .br_taken(br_taken), .halted(halted_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every accepted instruction must match the next expected one.
  always @(negedge clk) begin
    if (rst_n && instr_valid && instr_ready) begin
      chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_opcode",  32'(instr_opcode),  32'(e.op));
        chk("sb_operand", 32'(instr_operand), 32'(e.opr));
        chk("sb_has_opr", 32'(instr_has_opr), 32'(e.has));
        chk("sb_pc",      32'(instr_pc),      32'(e.pc));
        $display("accept pc=%04h opcode=%0d operand=%04h has_opr=%0d",
                 instr_pc, instr_opcode, instr_operand, instr_has_opr);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] op, input logic [15:0] opr,
                      input logic has, input logic [15:0] pc);
    exp_t e;
    e.op = op; e.opr = opr; e.has = has; e.pc = pc;
    sb.push_back(e);
  endtask

  // Counts cycles until instr_valid; with do_start the count starts at the start cycle.
  task automatic wait_valid(input bit do_start, output int cnt);
    cnt = 0;
    if (do_start) start = 1'b1;
    do begin
      tick();
      start = 1'b0;
      cnt++;
    end while (!instr_valid && cnt < 40);
    if (!instr_valid) chk("valid_timeout", 32'(instr_valid), 32'd1);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    tick();
    chk({tag, "_valid"},  32'(instr_valid), 32'd0);
    chk({tag, "_halted"}, 32'(halted),      32'd0);
    chk({tag, "_addr"},   32'(iram_addr),   32'h0000);
    chk({tag, "_opcode"}, 32'(instr_opcode), 32'd0);
    rst_n = 1'b1;
    sb.delete();
    $display("reset %s done", tag);
  endtask

  task automatic do_branch(input bit taken);
    tick();
    tick();
    chk("brw_holds_valid_low", 32'(instr_valid), 32'd0);
    br_done  = 1'b1;
    br_taken = taken;
    tick();
    br_done  = 1'b0;
    br_taken = 1'b0;
  endtask

  task automatic clear_low_mem;
    for (int i = 0; i < 64; i++) mem[i] = 16'd0;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'd0;
    rst_n = 1'b0; start = 1'b0; start_b = 1'b0;
    instr_ready = 1'b0; br_done = 1'b0; br_taken = 1'b0;
    tick();

    // 1: CLAC then ENDOP
    clear_low_mem();
    mem[0] = 16'd35; mem[1] = 16'd51;
    do_reset("t1_reset");
    chk("t1_b_reset_addr", 32'(iram_addr_b), 32'h0000_FFFF);
    instr_ready = 1'b1;
    push(16'd35, 16'd0, 1'b0, 16'd0);
    push(16'd51, 16'd0, 1'b0, 16'd1);
    wait_valid(1'b1, n);
    chk("t1_latency_1word", 32'(n), 32'd3);
    wait_valid(1'b0, n);
    chk("t1_latency_endop", 32'(n), 32'd3);
    tick();
    chk("t1_halted", 32'(halted), 32'd1);
    chk("t1_valid_after_halt", 32'(instr_valid), 32'd0);
    start = 1'b1; tick(); start = 1'b0;
    repeat (5) tick();
    chk("t1_halt_ignores_start", 32'({halted, instr_valid}), 32'b10);
    chk("t1_sb_empty", 32'(sb.size()), 32'd0);

    // 2: LDAC with operand, then sequential fetch at pc 2
    clear_low_mem();
    mem[0] = 16'd5; mem[1] = 16'd7; mem[2] = 16'd35; mem[3] = 16'd51;
    do_reset("t2_reset");
    push(16'd5, 16'd7, 1'b1, 16'd0);
    push(16'd35, 16'd0, 1'b0, 16'd2);
    push(16'd51, 16'd0, 1'b0, 16'd3);
    wait_valid(1'b1, n);
    chk("t2_latency_2word", 32'(n), 32'd5);
    wait_valid(1'b0, n);
    chk("t2_latency_next", 32'(n), 32'd3);
    chk("t2_addr_pc2", 32'(iram_addr), 32'd2);
    wait_valid(1'b0, n);
    tick();
    chk("t2_halted", 32'(halted), 32'd1);
    chk("t2_sb_empty", 32'(sb.size()), 32'd0);

    // 3: backpressure holds the instruction and the IRAM address
    clear_low_mem();
    mem[0] = 16'd9; mem[1] = 16'h1234; mem[2] = 16'd51;
    do_reset("t3_reset");
    instr_ready = 1'b0;
    push(16'd9, 16'h1234, 1'b1, 16'd0);
    push(16'd51, 16'd0, 1'b0, 16'd2);
    wait_valid(1'b1, n);
    chk("t3_latency", 32'(n), 32'd5);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3_hold_valid",   32'(instr_valid),   32'd1);
      chk("t3_hold_operand", 32'(instr_operand), 32'h1234);
      chk("t3_hold_addr",    32'(iram_addr),     32'd1);
    end
    instr_ready = 1'b1;
    tick();
    chk("t3_single_accept_valid", 32'(instr_valid), 32'd0);
    chk("t3_single_accept_sb",    32'(sb.size()),   32'd1);
    wait_valid(1'b0, n);
    tick();
    chk("t3_halted", 32'(halted), 32'd1);

    // 4: JUMP followed without br_done, JPPZ/JPNZ taken and not taken
    clear_low_mem();
    mem[0]  = 16'd46; mem[1]  = 16'd10;
    mem[10] = 16'd46; mem[11] = 16'd3;
    mem[3]  = 16'd62; mem[4]  = 16'd20;
    mem[20] = 16'd48; mem[21] = 16'd8;
    mem[8]  = 16'd46; mem[9]  = 16'd20;
    mem[22] = 16'd51;
    do_reset("t4_reset");
    push(16'd46, 16'd10, 1'b1, 16'd0);
    push(16'd46, 16'd3,  1'b1, 16'd10);
    push(16'd62, 16'd20, 1'b1, 16'd3);
    push(16'd48, 16'd8,  1'b1, 16'd20);
    push(16'd46, 16'd20, 1'b1, 16'd8);
    push(16'd48, 16'd8,  1'b1, 16'd20);
    push(16'd51, 16'd0,  1'b0, 16'd22);
    wait_valid(1'b1, n);
    wait_valid(1'b0, n);
    chk("t4_jump_latency", 32'(n), 32'd5);
    wait_valid(1'b0, n);
    do_branch(1'b1);
    wait_valid(1'b0, n);
    do_branch(1'b1);
    wait_valid(1'b0, n);
    wait_valid(1'b0, n);
    do_branch(1'b0);
    wait_valid(1'b0, n);
    tick();
    chk("t4_halted", 32'(halted), 32'd1);
    chk("t4_sb_empty", 32'(sb.size()), 32'd0);

    // 5: PC wrap from 0xFFFF on the second instance
    clear_low_mem();
    mem[16'hFFFF] = 16'd34; mem[0] = 16'd51;
    do_reset("t5_reset");
    chk("t5_b_reset_addr", 32'(iram_addr_b), 32'h0000_FFFF);
    instr_ready = 1'b1;
    n = 0;
    start_b = 1'b1;
    do begin
      tick();
      start_b = 1'b0;
      n++;
    end while (!valid_b && n < 40);
    chk("t5_latency",  32'(n),         32'd3);
    chk("t5_opcode",   32'(opcode_b),  32'd34);
    chk("t5_pc",       32'(pc_b),      32'h0000_FFFF);
    chk("t5_has_opr",  32'(has_opr_b), 32'd0);
    $display("accept(b) pc=%04h opcode=%0d", pc_b, opcode_b);
    tick();
    chk("t5_wrap_addr", 32'(iram_addr_b), 32'h0000_0000);
    n = 0;
    while (!valid_b && n < 40) begin
      tick();
      n++;
    end
    chk("t5_wrap_opcode", 32'(opcode_b), 32'd51);
    chk("t5_wrap_pc",     32'(pc_b),     32'd0);
    $display("accept(b) pc=%04h opcode=%0d", pc_b, opcode_b);
    tick();
    chk("t5_halted", 32'(halted_b), 32'd1);

    // 6a: reset while the operand word is in flight
    clear_low_mem();
    mem[0] = 16'd5; mem[1] = 16'd7; mem[2] = 16'd51;
    do_reset("t6_pre");
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    do_reset("t6a_mid_oprd");
    repeat (6) tick();
    chk("t6a_needs_start", 32'({instr_valid, iram_addr}), 32'd0);
    push(16'd5, 16'd7, 1'b1, 16'd0);
    push(16'd51, 16'd0, 1'b0, 16'd2);
    wait_valid(1'b1, n);
    chk("t6a_refetch_latency", 32'(n), 32'd5);
    wait_valid(1'b0, n);
    tick();
    chk("t6a_halted", 32'(halted), 32'd1);

    // 6b: reset while waiting for a branch result; br_done in IDLE is ignored
    clear_low_mem();
    mem[0] = 16'd48; mem[1] = 16'd8;
    do_reset("t6b_pre");
    push(16'd48, 16'd8, 1'b1, 16'd0);
    wait_valid(1'b1, n);
    tick();
    tick();
    chk("t6b_in_brw", 32'(instr_valid), 32'd0);
    do_reset("t6b_mid_brw");
    br_done = 1'b1; br_taken = 1'b1;
    tick();
    br_done = 1'b0; br_taken = 1'b0;
    repeat (4) tick();
    chk("t6b_idle_ignores_br", 32'({instr_valid, iram_addr}), 32'd0);
    chk("t6b_sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
